// File: rtl/karatsuba_pkg.sv
// Shared definitions for the karatsuba16 multiplier and its MAC stage:
// operand/product widths, MAC state encoding and an overflow helper.
package karatsuba_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Signed add overflow from the operand and result sign bits; the caller
    // clamps toward the common operand sign when this is set.
    function automatic logic sadd_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/karatsuba16.sv
// Combinational signed 16x16 multiplier, one level of Karatsuba on 8-bit halves.
// High halves are signed, low halves unsigned, so a = ah*2^8 + al exactly.
module karatsuba16
    import karatsuba_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic signed [15:0] z2;
    logic        [15:0] z0;
    logic signed [9:0]  sa;
    logic signed [9:0]  sb;
    logic signed [19:0] sa_x;
    logic signed [19:0] sb_x;
    logic signed [19:0] m;
    logic signed [19:0] z1;

    assign z2 = $signed({{8{a[15]}}, a[15:8]}) * $signed({{8{b[15]}}, b[15:8]});
    assign z0 = {8'b0, a[7:0]} * {8'b0, b[7:0]};

    assign sa   = $signed({{2{a[15]}}, a[15:8]} + {2'b00, a[7:0]});
    assign sb   = $signed({{2{b[15]}}, b[15:8]} + {2'b00, b[7:0]});
    assign sa_x = $signed({{10{sa[9]}}, sa});
    assign sb_x = $signed({{10{sb[9]}}, sb});
    assign m    = sa_x * sb_x;

    // Middle term ah*bl + al*bh recovered from the single cross product.
    assign z1 = m - $signed({{4{z2[15]}}, z2}) - $signed({4'b0, z0});

    assign p = {z2, 16'b0} + {{4{z1[19]}}, z1, 8'b0} + {16'b0, z0};

endmodule

// File: rtl/karatsuba16_mac.sv
// Streaming signed multiply-accumulate around karatsuba16 with valid/ready ports.
// Define KARATSUBA_MAC_SAT_EN for a saturating accumulator with sticky overflow.
module karatsuba16_mac
    import karatsuba_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t                   state;
    logic [OP_W-1:0]          a_r;
    logic [OP_W-1:0]          b_r;
    logic                     last_r;
    logic                     v1;
    logic [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]  p_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum_next;
    logic [CNT_W-1:0]         count;
    logic                     accept;
    logic                     res_hs;
    logic                     clamp;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign res_hs    = out_valid && out_ready;

    karatsuba16 u_mul (
        .a (a_r),
        .b (b_r),
        .p (prod)
    );

    assign p_ext = ACC_W'($signed(prod));

`ifdef KARATSUBA_MAC_SAT_EN
    logic signed [ACC_W-1:0] raw_sum;
    logic                    ovf;

    always_comb begin
        raw_sum  = acc + p_ext;
        clamp    = sadd_ovf(acc[ACC_W-1], p_ext[ACC_W-1], raw_sum[ACC_W-1]);
        sum_next = raw_sum;
        if (clamp)
            sum_next = acc[ACC_W-1] ? $signed({1'b1, {(ACC_W-1){1'b0}}})
                                    : $signed({1'b0, {(ACC_W-1){1'b1}}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n || res_hs)
            ovf <= 1'b0;
        else if (v1 && clamp)
            ovf <= 1'b1;
    end

    assign out_ovf = ovf;
`else
    always_comb begin
        clamp    = 1'b0;
        sum_next = acc + p_ext;
    end

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ACCUM;
            v1     <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            last_r <= 1'b0;
            acc    <= '0;
            count  <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a_r    <= in_a;
                b_r    <= in_b;
                last_r <= in_last;
            end

            if (res_hs) begin
                acc   <= '0;
                count <= '0;
            end else if (v1) begin
                acc <= sum_next;
                if (count != '1)
                    count <= count + 1'b1;
            end

            case (state)
                ACCUM:   if (accept && in_last) state <= FLUSH;
                FLUSH:   if (v1 && last_r)      state <= HOLD;
                HOLD:    if (out_ready)         state <= ACCUM;
                default:                        state <= ACCUM;
            endcase
        end
    end

    assign out_acc   = acc;
    assign out_count = count;

endmodule
